coeff_bus_master: RTL and testbench

// Host-side initiator for the FIR control bus: generates iCsnRam/iWrnRam/iAddrRam/iWtDtRam
// and iCoeffUpdateFlag for the FIR control FSM. Loads a coefficient stream into all

---
 rtl/coeff_bus_master_pkg.sv | 27 ++
 rtl/coeff_bus_master_addr_gen.sv | 35 +++
 rtl/coeff_bus_master.sv | 152 +++++++++++++++
 tb/tb_coeff_bus_master.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/coeff_bus_master_pkg.sv
// Shared definitions for the FIR coefficient bus master: bus geometry, state encoding and
// the bank/tap address packing helper.
package coeff_bus_master_pkg;

    localparam int unsigned P_NUM_TAP = 10;
    localparam int unsigned P_NUM_MOD = 4;

    localparam int unsigned TAP_W    = 4;
    localparam int unsigned BANK_W   = 2;
    localparam int unsigned ADDR_W   = 6;
    localparam int unsigned BANK_LSB = 4;  // addr[5:4] = bank, addr[3:0] = tap

    typedef enum logic [2:0] {
        S_IDLE,
        S_UPD_ARM,
        S_UPD_WR,
        S_UPD_END,
        S_RD,
        S_RD_END
    } state_t;

    function automatic logic [ADDR_W-1:0] make_addr(input logic [BANK_W-1:0] bank,
                                                    input logic [TAP_W-1:0]  tap);
        return (ADDR_W'(bank) << BANK_LSB) | ADDR_W'(tap);
    endfunction

endpackage

// File: rtl/coeff_bus_master_addr_gen.sv
// Tap/bank counter shared by write and read bursts; tap wraps to 0 and carries into bank.
module coeff_addr_gen
    import coeff_bus_master_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    output logic [TAP_W-1:0]  tap,
    output logic [BANK_W-1:0] bank,
    output logic              last_tap,
    output logic              last_bank
);

    assign last_tap  = (tap == TAP_W'(P_NUM_TAP - 1));
    assign last_bank = (bank == BANK_W'(P_NUM_MOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap  <= '0;
            bank <= '0;
        end else if (clr) begin
            tap  <= '0;
            bank <= '0;
        end else if (inc) begin
            if (last_tap) begin
                tap  <= '0;
                bank <= bank + 1'b1;
            end else begin
                tap <= tap + 1'b1;
            end
        end
    end

endmodule

// File: rtl/coeff_bus_master.sv
// Host-side FIR control bus initiator: loads coefficients into all banks via write bursts and
// issues one read burst per sample strobe, deferring strobes and starts that arrive while busy.
module coeff_bus_master
    import coeff_bus_master_pkg::*;
#(
    parameter int unsigned P_DW = 16
) (
    input  logic              iClk12M,
    input  logic              iRsn,
    input  logic              iEnSample600k,
    input  logic              iStart,
    input  logic              iCoeffValid,
    input  logic [P_DW-1:0]   iCoeffData,
    output logic              oCoeffReady,
    output logic              oCoeffUpdateFlag,
    output logic              oCsnRam,
    output logic              oWrnRam,
    output logic [ADDR_W-1:0] oAddrRam,
    output logic [P_DW-1:0]   oWtDtRam,
    output logic              oBusy,
    output logic              oUpdDone,
    output logic              oOverrun
);

    state_t            state;
    logic              pending;
    logic              start_pend;
    logic              go_upd;
    logic              go_rd;
    logic              beat;
    logic              clr;
    logic              inc;
    logic [TAP_W-1:0]  tap;
    logic [BANK_W-1:0] bank;
    logic              last_tap;
    logic              last_bank;

    coeff_addr_gen u_addr_gen (
        .clk       (iClk12M),
        .rst_n     (iRsn),
        .clr       (clr),
        .inc       (inc),
        .tap       (tap),
        .bank      (bank),
        .last_tap  (last_tap),
        .last_bank (last_bank)
    );

    // The counter leads the bus by one cycle: tap 0 is put on the bus while leaving S_IDLE.
    always_comb begin
        go_upd = iStart | start_pend;
        go_rd  = ~go_upd & (iEnSample600k | pending);
        beat   = iCoeffValid & oCoeffReady;
        clr    = 1'b0;
        inc    = 1'b0;
        case (state)
            S_IDLE:   if (go_rd) inc = 1'b1; else clr = 1'b1;
            S_UPD_WR: inc = beat;
            S_RD:     if (last_tap) clr = 1'b1; else inc = 1'b1;
            default:  clr = 1'b1;
        endcase
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            state            <= S_IDLE;
            pending          <= 1'b0;
            start_pend       <= 1'b0;
            oCoeffReady      <= 1'b0;
            oCoeffUpdateFlag <= 1'b0;
            oCsnRam          <= 1'b1;
            oWrnRam          <= 1'b1;
            oAddrRam         <= '0;
            oWtDtRam         <= '0;
            oBusy            <= 1'b0;
            oUpdDone         <= 1'b0;
            oOverrun         <= 1'b0;
        end else begin
            oUpdDone <= 1'b0;
            case (state)
                S_IDLE: begin
                    oCsnRam <= 1'b1;
                    oWrnRam <= 1'b1;
                    if (go_upd) begin
                        state            <= S_UPD_ARM;
                        oCoeffUpdateFlag <= 1'b1;
                        oBusy            <= 1'b1;
                        start_pend       <= 1'b0;
                        if (iEnSample600k) begin
                            if (pending) oOverrun <= 1'b1;
                            pending <= 1'b1;
                        end
                    end else if (go_rd) begin
                        state    <= S_RD;
                        oBusy    <= 1'b1;
                        oCsnRam  <= 1'b0;
                        oAddrRam <= make_addr(2'b00, tap);
                        // A fresh strobe arriving while a pending one is serviced waits its turn.
                        pending  <= pending & iEnSample600k;
                    end
                end
                S_UPD_ARM: begin
                    state       <= S_UPD_WR;
                    oCoeffReady <= 1'b1;
                end
                S_UPD_WR: begin
                    if (beat) begin
                        oCsnRam  <= 1'b0;
                        oWrnRam  <= 1'b0;
                        oAddrRam <= make_addr(bank, tap);
                        oWtDtRam <= iCoeffData;
                        if (last_tap && last_bank) begin
                            oUpdDone    <= 1'b1;
                            oCoeffReady <= 1'b0;
                            state       <= S_UPD_END;
                        end
                    end else begin
                        oCsnRam <= 1'b1;
                    end
                end
                S_UPD_END: begin
                    oCsnRam          <= 1'b1;
                    oWrnRam          <= 1'b1;
                    oCoeffUpdateFlag <= 1'b0;
                    oBusy            <= 1'b0;
                    state            <= S_IDLE;
                end
                S_RD: begin
                    oAddrRam <= make_addr(2'b00, tap);
                    if (last_tap) state <= S_RD_END;
                end
                S_RD_END: begin
                    oCsnRam <= 1'b1;
                    oBusy   <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (state != S_IDLE) begin
                if (iEnSample600k) begin
                    if (pending) oOverrun <= 1'b1;
                    else         pending  <= 1'b1;
                end
                if (iStart) start_pend <= 1'b1;
            end

            if (iStart) oOverrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_coeff_bus_master.sv
// Directed bench for coeff_bus_master: expected bus beats are queued as stimulus is driven
// and checked by a bus monitor as the DUT issues them.
module tb_coeff_bus_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0;
    logic        start = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] cdata = '0;
    logic        ready, flag, csn, wrn, busy, done, overrun;
    logic [5:0]  addr;
    logic [15:0] data;

    typedef struct packed {
        logic [5:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t        wr_q[$];
    logic [5:0] rd_q[$];
    wr_t        e_wr;
    logic [5:0] e_rd;

    int errors = 0, checks = 0, rd_bursts = 0, done_cnt = 0;

    always #5 clk = ~clk;

    coeff_bus_master #(.P_DW(16)) dut (
        .iClk12M          (clk),
        .iRsn             (rst_n),
        .iEnSample600k    (stb),
        .iStart           (start),
        .iCoeffValid      (valid),
        .iCoeffData       (cdata),
        .oCoeffReady      (ready),
        .oCoeffUpdateFlag (flag),
        .oCsnRam          (csn),
        .oWrnRam          (wrn),
        .oAddrRam         (addr),
        .oWtDtRam         (data),
        .oBusy            (busy),
        .oUpdDone         (done),
        .oOverrun         (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] addr_of(input int n);
        return {2'(n / 10), 4'(n % 10)};
    endfunction

    task automatic push_reads();
        for (int i = 0; i < 10; i++) rd_q.push_back(6'(i));
    endtask

    task automatic check_reset(input string tag);
        chk(tag, 32'({csn, wrn, flag, addr, data, ready, busy, done, overrun}),
            32'({1'b1, 1'b1, 27'd0}));
    endtask

    task automatic wait_quiet(input string tag);
        int q = 0;
        for (int i = 0; i < 300 && q < 3; i++) begin
            @(negedge clk);
            if (!busy) q++;
            else q = 0;
        end
        chk(tag, q, 3);
    endtask

    // Bus monitor: every selected cycle must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("no_flag_read", 32'(!csn && flag && wrn), 0);
            if (!csn && !wrn) begin
                chk("wr_q_nonempty", 32'(wr_q.size() != 0), 1);
                if (wr_q.size() != 0) begin
                    e_wr = wr_q.pop_front();
                    chk("wr_beat", 32'({flag, addr, data}), 32'({1'b1, e_wr.addr, e_wr.data}));
                end
            end else if (!csn) begin
                chk("rd_q_nonempty", 32'(rd_q.size() != 0), 1);
                if (rd_q.size() != 0) begin
                    e_rd = rd_q.pop_front();
                    chk("rd_beat", 32'({flag, addr}), 32'({1'b0, e_rd}));
                    if (addr == 6'd0) rd_bursts++;
                end
            end
            if (done) done_cnt++;
        end
    end

    // One coefficient update; optional strobes at cycle indices and reset after beat rst_at.
    task automatic run_update(input bit toggle, input int stb_a, input int stb_b,
                              input int rst_at, input bit settle);
        int n = 0;
        int c = 0;
        int flag_low = 0;
        int d0;
        bit rdy, acc;
        @(posedge clk); #1;
        d0    = done_cnt;
        start = 1'b1;
        valid = 1'b1;
        cdata = 16'h0100;
        stb   = (stb_a == 0);
        if (stb_a == 0) push_reads();
        while (n < 40 && c < 400) begin
            @(negedge clk);
            rdy = ready;
            if (c == 1) chk("arm", 32'({flag, csn, ready, busy, overrun}), 32'b11010);
            else if (c > 1 && !flag) flag_low++;
            acc = valid && rdy;
            @(posedge clk); #1;
            if (acc) begin
                wr_q.push_back({addr_of(n), 16'h0100 + 16'(n)});
                n++;
            end
            c++;
            start = 1'b0;
            if (rst_at >= 0 && n == rst_at) begin
                #2 rst_n = 1'b0;
                #1 check_reset("async_reset");
                valid = 1'b0;
                stb   = 1'b0;
                wr_q.delete();
                @(negedge clk); #1 rst_n = 1'b1;
                return;
            end
            stb = (c == stb_a || c == stb_b);
            if (c == stb_a) push_reads();
            valid = toggle ? ((c / 2) % 2 == 0) : 1'b1;
            cdata = 16'h0100 + 16'(n);
        end
        valid = 1'b0;
        stb   = 1'b0;
        start = 1'b0;
        chk("upd_beats", n, 40);
        chk("flag_held", flag_low, 0);
        if (settle) begin
            wait_quiet("upd_quiet");
            chk("upd_done_once", done_cnt - d0, 1);
            chk("upd_end_bus", 32'({flag, ready, csn}), 32'b001);
            chk("wr_q_empty", wr_q.size(), 0);
        end
    endtask

    initial begin
        int b0, d0, w;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        #1 rst_n = 1'b1;

        // Plain update with a continuously valid stream.
        run_update(1'b0, -1, -1, -1, 1'b1);

        // Single sample strobe from idle.
        @(posedge clk); #1;
        push_reads();
        stb = 1'b1;
        @(posedge clk); #1;
        stb = 1'b0;
        b0 = rd_bursts;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("rd_gap", 32'({csn, busy}), 32'b10);
        chk("rd_q_empty", rd_q.size(), 0);
        chk("rd_burst_cnt", rd_bursts - b0, 1);

        // Stalling stream.
        run_update(1'b1, -1, -1, -1, 1'b1);

        // Two strobes during an update, a third during the deferred read.
        b0 = rd_bursts;
        d0 = done_cnt;
        run_update(1'b0, 5, 12, -1, 1'b0);
        w = 0;
        while (!(csn == 1'b0 && wrn == 1'b1) && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("defer_rd_seen", 32'(w < 100), 1);
        chk("overrun_set", 32'(overrun), 1);
        stb = 1'b1;
        push_reads();
        @(posedge clk); #1;
        stb = 1'b0;
        wait_quiet("ovr_quiet");
        chk("ovr_done_once", done_cnt - d0, 1);
        chk("ovr_bursts", rd_bursts - b0, 2);
        chk("rd_q_empty2", rd_q.size(), 0);
        chk("overrun_sticky", 32'(overrun), 1);
        run_update(1'b0, -1, -1, -1, 1'b1);
        chk("overrun_cleared", 32'(overrun), 0);

        // iStart and strobe in the same cycle.
        b0 = rd_bursts;
        run_update(1'b0, 0, -1, -1, 1'b1);
        chk("same_cycle_bursts", rd_bursts - b0, 1);
        chk("rd_q_empty3", rd_q.size(), 0);

        // Reset mid-update, then a clean restart from address 0.
        run_update(1'b0, -1, -1, 17, 1'b0);
        @(negedge clk);
        check_reset("post_reset");
        run_update(1'b0, -1, -1, -1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
